div_unit: RTL and testbench
===========================

Name: div_unit

Overview:
- Iterative radix-2 restoring divider for DIV/DIVU in the E stage of the 5-stage MIPS pipeline.
- Consumes the E-stage divide request and operands.
- Produces quotient (LO) and remainder (HI) plus a one-cycle div_complete pulse, which the mul/div hazard logic uses to release its 33-cycle divide stall.
- Single clock domain; holds results stable until the next divide starts.

Parameters:
- WIDTH, 32, operand and result width; the iteration counter is clog2(WIDTH)+1 bits wide.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-low; reset==0 at a rising edge clears all state.
- div  input  1  E-stage instruction is DIV/DIVU; held high by the stalled pipeline.
- div_signed  input  1  1 = DIV (two's complement), 0 = DIVU; sampled at start.
- de_valid  input  1  E-stage instruction is valid.
- cancel  input  1  exception/flush; aborts any divide in progress.
- op_a  input  WIDTH  dividend (rs value); sampled at start.
- op_b  input  WIDTH  divisor (rt value); sampled at start.
- quotient  output  WIDTH  result for LO.
- remainder  output  WIDTH  result for HI.
- div_complete  output  1  one-cycle pulse; results valid.
- busy  output  1  high in BUSY and DONE.

Behaviour:
- Reset (reset==0): state=IDLE, counter=0, quotient=0, remainder=0, div_complete=0, busy=0. Reset mid-operation discards the divide; no pulse is generated.
- start = div & de_valid & ~cancel, evaluated only in IDLE.
- State machine:
  - IDLE: on start, latch |op_a|, |op_b| (raw values if div_signed=0), the sign of op_a, sign(op_a)^sign(op_b), div_signed and the zero-divisor flag. Clear the partial remainder, clear the counter, go to BUSY. Otherwise stay in IDLE.
  - BUSY: one restoring step per cycle. Shift {rem,quo} left by 1, trial-subtract the divisor, set quo LSB=1 and keep the difference when no borrow, else restore. Counter increments. The edge completing step WIDTH goes to DONE with sign-corrected results written to quotient/remainder.
  - DONE: div_complete=1 for exactly this cycle; next state is IDLE unconditionally.
- cancel in BUSY: next state IDLE; quotient/remainder keep their previous values; no pulse.
- cancel in DONE: the pulse still asserts, because the results are final.
- cancel and div together in IDLE: cancel wins and no start occurs.
- Latency: div first seen at cycle T0; BUSY T1..T32; div_complete=1 at T33 (33 cycles for WIDTH=32).
- The divider does not start in DONE. A back-to-back divide sampled at T34 in IDLE starts normally.
- div dropping in BUSY has no effect on the divide; only cancel or reset aborts it.
- Sign rules (signed mode):
  - quotient is negated when the operand signs differ;
  - remainder takes the sign of the dividend;
  - the invariant a = q*b + r holds.
- Overflow: 0x80000000 / 0xFFFFFFFF signed gives q=0x80000000, r=0. There is no trap.
- Divide by zero: q=0xFFFFFFFF, r=op_a as sampled, in both modes. No sign correction is applied. The full 33-cycle latency is still taken.
- quotient/remainder change only at the BUSY→DONE edge or at reset.

Test Plan:
- Unsigned: op_a=100, op_b=7, div_signed=0, div=de_valid=1 held -> div_complete exactly at T33 for one cycle, q=14, r=2, busy high T1..T33.
- Signed: op_a=0xFFFFFF9C(-100), op_b=7 -> q=0xFFFFFFF2(-14), r=0xFFFFFFFE(-2). Repeat with op_a=100, op_b=-7 -> q=-14, r=2.
- Corner cases:
  - 0x80000000 / 0xFFFFFFFF signed -> q=0x80000000, r=0.
  - 0x12345678 / 0 (either mode) -> q=0xFFFFFFFF, r=0x12345678 at T33.
- Abort: cancel=1 at T10 -> IDLE at T11, no div_complete, prior q/r unchanged. reset=0 at T20 -> q=r=0, busy=0. A new div afterwards completes after 33 cycles.
- Back-to-back: 50/5 then 9/4 with div held high across the pulse -> pulse at T33 (q=10, r=0), second start sampled at T34, pulse at T67 (q=2, r=1). cancel and div together in IDLE -> no start.

Source files
------------

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for DIV/DIVU in the E stage.
// One quotient bit per cycle. Operands are converted to magnitudes at start,
// and the signs are corrected on the edge that completes the last step.
// quotient/remainder hold their values until the next completed divide or reset.
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             div,
  input  logic             div_signed,
  input  logic             de_valid,
  input  logic             cancel,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_complete,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] dvsr_q;
  logic             a_neg_q;
  logic             q_neg_q;
  logic             sgn_q;
  logic             zero_q;
  logic [WIDTH-1:0] quotient_q;
  logic [WIDTH-1:0] remainder_q;
  logic             div_complete_q;
  logic             busy_q;

  logic             start_s;
  logic [WIDTH-1:0] abs_a_s;
  logic [WIDTH-1:0] abs_b_s;
  logic [WIDTH:0]   rem_shift_s;
  logic [WIDTH:0]   diff_s;
  logic [WIDTH-1:0] rem_d;
  logic [WIDTH-1:0] quo_d;
  logic [WIDTH-1:0] quot_fix_d;
  logic [WIDTH-1:0] rem_fix_d;
  logic             last_step_s;

  assign quotient     = quotient_q;
  assign remainder    = remainder_q;
  assign div_complete = div_complete_q;
  assign busy         = busy_q;

  // Start qualification, operand magnitudes and one restoring step with sign fix-up.
  always_comb begin
    start_s     = div & de_valid & ~cancel;
    abs_a_s     = (div_signed && op_a[WIDTH-1]) ? (~op_a + {{(WIDTH-1){1'b0}}, 1'b1}) : op_a;
    abs_b_s     = (div_signed && op_b[WIDTH-1]) ? (~op_b + {{(WIDTH-1){1'b0}}, 1'b1}) : op_b;
    last_step_s = (cnt_q == CW'(WIDTH - 1));
    rem_shift_s = {rem_q, quo_q[WIDTH-1]};
    diff_s      = rem_shift_s - {1'b0, dvsr_q};
    if (!diff_s[WIDTH]) begin
      rem_d = diff_s[WIDTH-1:0];
      quo_d = {quo_q[WIDTH-2:0], 1'b1};
    end else begin
      rem_d = rem_shift_s[WIDTH-1:0];
      quo_d = {quo_q[WIDTH-2:0], 1'b0};
    end
    // With a zero divisor every trial subtract succeeds, so the remainder
    // register ends up holding |op_a|; re-applying the dividend sign below
    // therefore reproduces op_a exactly as sampled.
    if (zero_q) begin
      quot_fix_d = {WIDTH{1'b1}};
    end else if (sgn_q && q_neg_q) begin
      quot_fix_d = ~quo_d + {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      quot_fix_d = quo_d;
    end
    if (sgn_q && a_neg_q) begin
      rem_fix_d = ~rem_d + {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      rem_fix_d = rem_d;
    end
  end

  // Divider FSM: operand capture, iteration, result write-back and completion pulse.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q        <= IDLE;
      cnt_q          <= {CW{1'b0}};
      rem_q          <= {WIDTH{1'b0}};
      quo_q          <= {WIDTH{1'b0}};
      dvsr_q         <= {WIDTH{1'b0}};
      a_neg_q        <= 1'b0;
      q_neg_q        <= 1'b0;
      sgn_q          <= 1'b0;
      zero_q         <= 1'b0;
      quotient_q     <= {WIDTH{1'b0}};
      remainder_q    <= {WIDTH{1'b0}};
      div_complete_q <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          div_complete_q <= 1'b0;
          if (start_s) begin
            quo_q   <= abs_a_s;
            dvsr_q  <= abs_b_s;
            rem_q   <= {WIDTH{1'b0}};
            cnt_q   <= {CW{1'b0}};
            a_neg_q <= op_a[WIDTH-1];
            q_neg_q <= op_a[WIDTH-1] ^ op_b[WIDTH-1];
            sgn_q   <= div_signed;
            zero_q  <= (op_b == {WIDTH{1'b0}});
            busy_q  <= 1'b1;
            state_q <= BUSY;
          end else begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        BUSY: begin
          if (cancel) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            cnt_q <= cnt_q + {{(CW-1){1'b0}}, 1'b1};
            if (last_step_s) begin
              quotient_q     <= quot_fix_d;
              remainder_q    <= rem_fix_d;
              div_complete_q <= 1'b1;
              state_q        <= DONE;
            end else begin
              state_q <= BUSY;
            end
          end
        end
        DONE: begin
          div_complete_q <= 1'b0;
          busy_q         <= 1'b0;
          state_q        <= IDLE;
        end
        default: begin
          div_complete_q <= 1'b0;
          busy_q         <= 1'b0;
          state_q        <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed test-plan cases plus random
// operands checked against an arithmetic reference model.
module tb_div_unit;

  logic        clk;
  logic        reset;
  logic        div;
  logic        div_signed;
  logic        de_valid;
  logic        cancel;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_complete;
  logic        busy;

  int vectors;
  int miscompares;
  logic [31:0] last_q;
  logic [31:0] last_r;

  div_unit #(.WIDTH(32)) dut (
    .clk          (clk),
    .reset        (reset),
    .div          (div),
    .div_signed   (div_signed),
    .de_valid     (de_valid),
    .cancel       (cancel),
    .op_a         (op_a),
    .op_b         (op_b),
    .quotient     (quotient),
    .remainder    (remainder),
    .div_complete (div_complete),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer division with the MIPS corner-case rules.
  function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic s,
                                output logic [31:0] q, output logic [31:0] r);
    int sa;
    int sb;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (!s) begin
      q = a / b;
      r = a % b;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000;
      r = 32'd0;
    end else begin
      sa = int'(a);
      sb = int'(b);
      q = 32'(sa / sb);
      r = 32'(sa % sb);
    end
  endfunction

  task automatic start_div(input logic [31:0] a, input logic [31:0] b, input logic s);
    @(negedge clk);
    op_a       = a;
    op_b       = b;
    div_signed = s;
    div        = 1'b1;
    de_valid   = 1'b1;
  endtask

  // Counts cycles after T0 up to and including the pulse; 100 means no pulse.
  task automatic wait_pulse(output int cyc, output int busy_low);
    cyc      = 0;
    busy_low = 0;
    while (cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (!busy) busy_low++;
      if (div_complete) break;
    end
  endtask

  task automatic do_div(input logic [31:0] a, input logic [31:0] b, input logic s, input string tag);
    int cyc;
    int bl;
    logic [31:0] eq;
    logic [31:0] er;
    model(a, b, s, eq, er);
    start_div(a, b, s);
    wait_pulse(cyc, bl);
    div      = 1'b0;
    de_valid = 1'b0;
    chk({tag, "_lat"}, 32'(cyc), 32'd33);
    chk({tag, "_busy"}, 32'(bl), 32'd0);
    chk({tag, "_q"}, quotient, eq);
    chk({tag, "_r"}, remainder, er);
    last_q = eq;
    last_r = er;
    @(negedge clk);
    chk({tag, "_pulse_once"}, {31'd0, div_complete}, 32'd0);
    chk({tag, "_idle"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int cyc;
    int cyc2;
    int bl;
    int pulses;
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b0;
    div         = 1'b0;
    div_signed  = 1'b0;
    de_valid    = 1'b0;
    cancel      = 1'b0;
    op_a        = 32'd0;
    op_b        = 32'd0;
    repeat (3) @(negedge clk);
    chk("rst_q", quotient, 32'd0);
    chk("rst_r", remainder, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_pulse", {31'd0, div_complete}, 32'd0);
    reset = 1'b1;

    do_div(32'd100, 32'd7, 1'b0, "u100_7");
    do_div(32'hFFFF_FF9C, 32'd7, 1'b1, "s-100_7");
    do_div(32'd100, 32'hFFFF_FFF9, 1'b1, "s100_-7");
    do_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, "ovf");
    do_div(32'h1234_5678, 32'd0, 1'b0, "dz_u");
    do_div(32'h1234_5678, 32'd0, 1'b1, "dz_s");
    do_div(32'hF000_0001, 32'd0, 1'b1, "dz_neg");

    // Abort with cancel at T10: no pulse, previous results untouched.
    start_div(32'd1000, 32'd3, 1'b0);
    repeat (10) @(negedge clk);
    cancel = 1'b1;
    div    = 1'b0;
    @(negedge clk);
    cancel   = 1'b0;
    de_valid = 1'b0;
    chk("cancel_busy", {31'd0, busy}, 32'd0);
    chk("cancel_q", quotient, last_q);
    chk("cancel_r", remainder, last_r);
    pulses = 0;
    repeat (40) begin
      @(negedge clk);
      if (div_complete) pulses++;
    end
    chk("cancel_nopulse", 32'(pulses), 32'd0);

    // Reset at T20 discards the divide and clears the results.
    start_div(32'd1000, 32'd3, 1'b0);
    repeat (20) @(negedge clk);
    reset = 1'b0;
    div   = 1'b0;
    @(negedge clk);
    chk("midrst_q", quotient, 32'd0);
    chk("midrst_r", remainder, 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    reset = 1'b1;
    do_div(32'd77, 32'd5, 1'b0, "after_rst");

    // Back-to-back with div held across the pulse.
    start_div(32'd50, 32'd5, 1'b0);
    wait_pulse(cyc, bl);
    chk("b2b1_lat", 32'(cyc), 32'd33);
    chk("b2b1_q", quotient, 32'd10);
    chk("b2b1_r", remainder, 32'd0);
    op_a = 32'd9;
    op_b = 32'd4;
    wait_pulse(cyc2, bl);
    div      = 1'b0;
    de_valid = 1'b0;
    chk("b2b2_lat", 32'(cyc + cyc2), 32'd67);
    chk("b2b2_q", quotient, 32'd2);
    chk("b2b2_r", remainder, 32'd1);
    last_q = 32'd2;
    last_r = 32'd1;
    @(negedge clk);

    // cancel and div together in IDLE: no start.
    op_a     = 32'd40;
    op_b     = 32'd3;
    div      = 1'b1;
    de_valid = 1'b1;
    cancel   = 1'b1;
    bl = 0;
    repeat (5) begin
      @(negedge clk);
      if (busy) bl++;
    end
    div      = 1'b0;
    de_valid = 1'b0;
    cancel   = 1'b0;
    chk("cancel_idle_busy", 32'(bl), 32'd0);
    chk("cancel_idle_q", quotient, last_q);

    // Random operands, with corner values mixed in.
    for (int i = 0; i < 24; i++) begin
      a = $urandom;
      b = $urandom;
      s = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: b = 32'hFFFF_FFFF;
        2: a = 32'h8000_0000;
        3: b = 32'($urandom_range(1, 20));
        4: b = b >> $urandom_range(1, 31);
        default: ;
      endcase
      do_div(a, b, s, $sformatf("rnd%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
